// File: rtl/alu_seq.sv
// alu_seq: issue/writeback sequencer sitting between decode/register-read and
// the ALU. One instruction in flight at a time.
//
// Flow: IDLE latches an instruction on start, ISSUE pulses alu_en, then either
// CAPT (ordinary op, ALU result registered one cycle later) or WAIT (serial
// shift, alu_en held until alu_sl_ok or timeout), then WB offers the captured
// result over a valid/ready handshake.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               issue request, sampled only in IDLE
//   decinst             decoded instruction: [6:0] opcode, [9:7] funct3, [11:10] funct7 flags
//   rs1_data, rs2_data  register operands
//   imm                 sign-extended immediate
//   rd_addr             destination register
//   alu_result/alu_cmp/alu_carry/alu_sl_ok  ALU return path
//   wb_ready            writeback stage accepts the result
//   busy                high outside IDLE
//   alu_en              ALU enable (ISSUE and WAIT)
//   alu_decinst/alu_op1/alu_rs2/alu_inm  latched instruction and operands to the ALU
//   wb_valid/wb_data/wb_rd/wb_we/wb_cmp/wb_carry  writeback offer
//   err                 sticky shift-timeout flag, cleared only by reset
module alu_seq #(
  parameter int unsigned SHIFT_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] decinst,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] alu_result,
  input  logic        alu_cmp,
  input  logic        alu_carry,
  input  logic        alu_sl_ok,
  input  logic        wb_ready,
  output logic        busy,
  output logic        alu_en,
  output logic [11:0] alu_decinst,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_inm,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        wb_cmp,
  output logic        wb_carry,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(SHIFT_TIMEOUT + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // CAPT covers the one-cycle registered ALU latency on the non-shift path.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_WAIT,
    S_WB
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              is_shift;
  logic              timeout;

  always_comb begin
    is_shift = ((alu_decinst[6:0] == OPC_OP) || (alu_decinst[6:0] == OPC_OP_IMM)) &&
               ((alu_decinst[9:7] == 3'b001) || (alu_decinst[9:7] == 3'b101));
    // Asserted during the SHIFT_TIMEOUT-th WAIT cycle.
    timeout  = (cnt == CNT_W'(SHIFT_TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: state_nx = is_shift ? S_WAIT : S_CAPT;
      S_CAPT:  state_nx = S_WB;
      S_WAIT:  if (alu_sl_ok || timeout) state_nx = S_WB;
      S_WB:    if (wb_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy     = (state != S_IDLE);
    alu_en   = (state == S_ISSUE) || (state == S_WAIT);
    wb_valid = (state == S_WB);
    wb_we    = (state == S_WB) && (wb_rd != 5'd0) && (alu_decinst[6:0] != OPC_BRANCH);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_decinst <= '0;
      alu_op1     <= '0;
      alu_rs2     <= '0;
      alu_inm     <= '0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_cmp      <= 1'b0;
      wb_carry    <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            alu_decinst <= decinst;
            alu_op1     <= rs1_data;
            alu_rs2     <= rs2_data;
            alu_inm     <= imm;
            wb_rd       <= rd_addr;
          end
        end
        S_ISSUE: cnt <= '0;
        S_CAPT: begin
          wb_data  <= alu_result;
          wb_cmp   <= alu_cmp;
          wb_carry <= alu_carry;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // sl_ok takes precedence over a coincident timeout.
          if (alu_sl_ok) begin
            wb_data  <= alu_result;
            wb_carry <= alu_carry;
          end else if (timeout) begin
            err     <= 1'b1;
            wb_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq. A small behavioural ALU answers the
// sequencer (registered ADD/SUB/BEQ, serial SRA with a programmable sl_ok);
// every checked value is a hand-computed constant.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] decinst;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd_addr;
  logic [31:0] alu_result;
  logic        alu_cmp, alu_carry, alu_sl_ok;
  logic        wb_ready;
  logic        busy, alu_en, wb_valid, wb_we, wb_cmp, wb_carry, err;
  logic [11:0] alu_decinst;
  logic [31:0] alu_op1, alu_rs2, alu_inm, wb_data;
  logic [4:0]  wb_rd;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  logic sl_enable = 1'b1;
  int   sh_cnt    = 0;

  localparam logic [11:0] I_ADD = 12'b000000110011;
  localparam logic [11:0] I_SUB = 12'b100000110011;
  localparam logic [11:0] I_SRA = 12'b011010010011;
  localparam logic [11:0] I_BEQ = 12'b000001100011;

  always #5 clk = ~clk;

  alu_seq #(.SHIFT_TIMEOUT(40)) dut (
    .clk(clk), .reset(reset), .start(start), .decinst(decinst),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_addr(rd_addr),
    .alu_result(alu_result), .alu_cmp(alu_cmp), .alu_carry(alu_carry),
    .alu_sl_ok(alu_sl_ok), .wb_ready(wb_ready), .busy(busy), .alu_en(alu_en),
    .alu_decinst(alu_decinst), .alu_op1(alu_op1), .alu_rs2(alu_rs2),
    .alu_inm(alu_inm), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_cmp(wb_cmp), .wb_carry(wb_carry), .err(err)
  );

  // Behavioural ALU: one-cycle registered result, serial SRA reports sl_ok
  // on its 4th enabled cycle when sl_enable is set.
  always @(posedge clk) begin
    logic [32:0] sum;
    alu_sl_ok <= 1'b0;
    if (alu_en) begin
      if (alu_decinst == I_SRA) begin
        sh_cnt <= sh_cnt + 1;
        if (sl_enable && sh_cnt == 3) begin
          alu_sl_ok  <= 1'b1;
          alu_result <= $signed(alu_op1) >>> alu_inm[4:0];
          alu_carry  <= 1'b0;
        end
      end else if (alu_decinst[6:0] == 7'b1100011) begin
        alu_result <= '0;
        alu_cmp    <= (alu_op1 == alu_rs2);
        alu_carry  <= 1'b0;
      end else begin
        if (alu_decinst[11]) sum = {1'b0, alu_op1} - {1'b0, alu_rs2};
        else                 sum = {1'b0, alu_op1} + {1'b0, alu_rs2};
        alu_result <= sum[31:0];
        alu_carry  <= sum[32];
        alu_cmp    <= 1'b0;
      end
    end else begin
      sh_cnt <= 0;
    end
  end

  always @(posedge clk) if (!reset && wb_valid && wb_ready) hs_cnt <= hs_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [11:0] d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] rd);
    decinst  = d;
    rs1_data = a;
    rs2_data = b;
    imm      = im;
    rd_addr  = rd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Bounded wait for wb_valid; an expired bound is a failed comparison.
  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (!wb_valid && n < limit) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, wb_valid}, 32'd1);
  endtask

  initial begin
    int hs0;
    reset = 1'b1; start = 1'b0; decinst = '0; rs1_data = '0; rs2_data = '0;
    imm = '0; rd_addr = '0; wb_ready = 1'b1;
    alu_result = '0; alu_cmp = 1'b0; alu_carry = 1'b0; alu_sl_ok = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // ADD: alu_en one cycle, wb_valid 2 cycles after start sample
    issue(I_ADD, 32'hC0404040, 32'h00000FFF, 32'd0, 5'd5);
    chk("add_en_issue", {31'd0, alu_en}, 32'd1);
    chk("add_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("add_en_off", {31'd0, alu_en}, 32'd0);
    chk("add_valid_early", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("add_valid", {31'd0, wb_valid}, 32'd1);
    chk("add_data", wb_data, 32'hC040503F);
    chk("add_we", {31'd0, wb_we}, 32'd1);
    chk("add_rd", {27'd0, wb_rd}, 32'd5);
    chk("add_carry", {31'd0, wb_carry}, 32'd0);
    tick();
    chk("add_idle", {31'd0, busy}, 32'd0);
    chk("add_valid_drop", {31'd0, wb_valid}, 32'd0);

    // SUB with 4 cycles of backpressure
    wb_ready = 1'b0;
    issue(I_SUB, 32'hC0404040, 32'h00000FFF, 32'd0, 5'd6);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("sub_hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("sub_hold_data", wb_data, 32'hC0403041);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    chk("sub_busy_after", {31'd0, busy}, 32'd0);
    chk("sub_we_after", {31'd0, wb_we}, 32'd0);

    // SRA serial shift with a start pulse while busy
    hs0 = hs_cnt;
    issue(I_SRA, 32'hC0404040, 32'd0, 32'd4, 5'd9);
    tick();
    chk("sra_en_wait", {31'd0, alu_en}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sra_en_wait2", {31'd0, alu_en}, 32'd1);
    wait_valid("sra_valid_timeout", 20);
    chk("sra_data", wb_data, 32'hFC040404);
    chk("sra_err", {31'd0, err}, 32'd0);
    chk("sra_en_drop", {31'd0, alu_en}, 32'd0);
    tick(); tick(); tick();
    chk("busy_start_ignored", {31'd0, busy}, 32'd0);
    chk("busy_start_hs", hs_cnt - hs0, 32'd1);

    // Shift timeout: ISSUE plus 40 WAIT cycles
    sl_enable = 1'b0;
    issue(I_SRA, 32'hC0404040, 32'd0, 32'd4, 5'd9);
    for (int i = 0; i < 40; i++) tick();
    chk("to_err_early", {31'd0, err}, 32'd0);
    chk("to_valid_early", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_data", wb_data, 32'd0);
    tick();
    issue(I_ADD, 32'hC0404040, 32'h00000FFF, 32'd0, 5'd5);
    tick(); tick();
    chk("to_add_data", wb_data, 32'hC040503F);
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    tick();

    // Branch: compare captured, no register write
    issue(I_BEQ, 32'h00001234, 32'h00001234, 32'd0, 5'd7);
    tick(); tick();
    chk("beq_valid", {31'd0, wb_valid}, 32'd1);
    chk("beq_cmp", {31'd0, wb_cmp}, 32'd1);
    chk("beq_we", {31'd0, wb_we}, 32'd0);
    tick();

    // ADD to x0: no register write
    issue(I_ADD, 32'h00000001, 32'h00000002, 32'd0, 5'd0);
    tick(); tick();
    chk("x0_valid", {31'd0, wb_valid}, 32'd1);
    chk("x0_data", wb_data, 32'h00000003);
    chk("x0_we", {31'd0, wb_we}, 32'd0);
    tick();

    // Reset in the middle of WAIT
    issue(I_SRA, 32'hC0404040, 32'd0, 32'd4, 5'd9);
    tick(); tick();
    chk("rw_en_before", {31'd0, alu_en}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rw_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rw_err", {31'd0, err}, 32'd0);
    chk("rw_wb_data", wb_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
